// File: rtl/address_router_pkg.sv
// address_router_pkg: shared state encoding, slave limit and default address map for address_router.
package address_router_pkg;
  localparam int MAX_SLAVES = 8;
  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;
  localparam logic [3:0][31:0] DEFAULT_BASE = {32'h8000_0000, 32'hE001_0000, 32'hE000_0000, 32'h0000_0000};
  localparam logic [3:0][31:0] DEFAULT_MASK = {32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFC00_0000};
endpackage

// File: rtl/address_router_match.sv
// addr_region_match: N-way masked address compare with lowest-index priority encode.
module addr_region_match
  import address_router_pkg::*;
#(
  parameter int N = 4,
  parameter int SW = 2,
  parameter logic [N-1:0][31:0] BASE = DEFAULT_BASE,
  parameter logic [N-1:0][31:0] MASK = DEFAULT_MASK
) (
  input  logic [31:0]   addr,
  output logic          hit,
  output logic [SW-1:0] sel
);
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = N - 1; i >= 0; i--)
      if ((addr & MASK[i]) == BASE[i]) begin
        hit = 1'b1;
        sel = SW'(i);
      end
  end
endmodule

// File: rtl/address_router.sv
// address_router: decodes CPU data requests onto one of N_SLAVES slaves and returns ack/rdata/error.
// Optional slave-ack timeout is enabled by defining ADDRESS_ROUTER_TIMEOUT_EN.
module address_router
  import address_router_pkg::*;
#(
  parameter int N_SLAVES = 4,
  parameter logic [N_SLAVES-1:0][31:0] REGION_BASE = DEFAULT_BASE,
  parameter logic [N_SLAVES-1:0][31:0] REGION_MASK = DEFAULT_MASK,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpud_request,
  input  logic [31:0]              cpud_addr,
  output logic [31:0]              cpud_rdata,
  output logic                     cpud_ack,
  output logic                     cpud_error,
  output logic [N_SLAVES-1:0]      slv_req,
  input  logic [N_SLAVES-1:0]      slv_ack,
  input  logic [32*N_SLAVES-1:0]   slv_rdata
);
  localparam int SW = N_SLAVES > 1 ? $clog2(N_SLAVES) : 1;
  if (N_SLAVES < 1 || N_SLAVES > MAX_SLAVES || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("address_router: parameter out of range");
  end
  state_t state;
  logic [SW-1:0] sel_q, hit_sel;
  logic hit, req_go, wait_ack, timeout;
  logic [N_SLAVES-1:0][31:0] rd_arr;
  addr_region_match #(.N(N_SLAVES), .SW(SW), .BASE(REGION_BASE), .MASK(REGION_MASK)) u_match (
    .addr(cpud_addr),
    .hit (hit),
    .sel (hit_sel)
  );
  assign rd_arr   = slv_rdata;
  assign req_go   = !reset && state == IDLE && cpud_request && hit;
  assign wait_ack = state == WAIT && slv_ack[sel_q];
`ifdef ADDRESS_ROUTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
  assign timeout = state == WAIT && cnt == TO;
  always_ff @(posedge clock)
    if (reset || state != WAIT) cnt <= '0;
    else cnt <= cnt + CW'(1);
`else
  assign timeout = 1'b0;
`endif
  // Slave ack beats a coincident timeout, so error needs a timeout without ack.
  assign slv_req    = req_go ? N_SLAVES'(1) << hit_sel : '0;
  assign cpud_ack   = !reset && (state == ERR || wait_ack || timeout);
  assign cpud_error = !reset && (state == ERR || (timeout && !wait_ack));
  assign cpud_rdata = (!reset && wait_ack) ? rd_arr[sel_q] : '0;
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      sel_q <= '0;
    end else
      case (state)
        IDLE:
          if (cpud_request) begin
            state <= hit ? WAIT : ERR;
            sel_q <= hit_sel;
          end
        WAIT: if (wait_ack || timeout) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_address_router.sv
// tb_address_router: directed stimulus with a queue-based scoreboard checking slv_req and cpud_ack events.
module tb_address_router;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic cpud_request = 1'b0;
  logic [31:0] cpud_addr = '0;
  logic [31:0] cpud_rdata;
  logic cpud_ack, cpud_error;
  logic [3:0] slv_req;
  logic [3:0] slv_ack = '0;
  logic [3:0][31:0] rd = '0;
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  typedef struct {int cyc; logic [31:0] data; logic err;} ack_t;
  typedef struct {int cyc; logic [3:0] v;} req_t;
  ack_t ack_q[$];
  req_t req_q[$];
  ack_t a;
  req_t r;

  address_router #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .cpud_request(cpud_request), .cpud_addr(cpud_addr),
    .cpud_rdata(cpud_rdata), .cpud_ack(cpud_ack), .cpud_error(cpud_error),
    .slv_req(slv_req), .slv_ack(slv_ack), .slv_rdata(rd)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic exp_req(input int c, input logic [3:0] v);
    req_q.push_back('{c, v});
  endtask

  task automatic exp_ack(input int c, input logic [31:0] d, input logic e);
    ack_q.push_back('{c, d, e});
  endtask

  always @(negedge clock) begin
    if (slv_req != '0) begin
      if (req_q.size() == 0) check("unexpected_slv_req", 64'(slv_req), 64'(0));
      else begin
        r = req_q.pop_front();
        check("slv_req_cycle", 64'(cyc), 64'(r.cyc));
        check("slv_req_value", 64'(slv_req), 64'(r.v));
      end
    end
    if (cpud_ack) begin
      if (ack_q.size() == 0) check("unexpected_ack", 64'(cpud_ack), 64'(0));
      else begin
        a = ack_q.pop_front();
        check("ack_cycle", 64'(cyc), 64'(a.cyc));
        check("ack_rdata", 64'(cpud_rdata), 64'(a.data));
        check("ack_error", 64'(cpud_error), 64'(a.err));
      end
    end else begin
      check("rdata_idle_zero", 64'(cpud_rdata), 64'(0));
      check("error_idle_zero", 64'(cpud_error), 64'(0));
    end
  end

  initial begin
    int c;
    cpud_request = 1'b1;
    cpud_addr = 32'h0000_1000;
    slv_ack = 4'hF;
    rd = {4{32'hFFFF_FFFF}};
    tick(2);
    check("reset_slv_req", 64'(slv_req), 64'(0));
    check("reset_ack", 64'(cpud_ack), 64'(0));
    check("reset_error", 64'(cpud_error), 64'(0));
    check("reset_rdata", 64'(cpud_rdata), 64'(0));
    cpud_request = 1'b0;
    slv_ack = '0;
    rd = '0;
    reset = 1'b0;
    tick();
    // Single hit to SRAM, ack two cycles later
    c = cyc; cpud_request = 1'b1; cpud_addr = 32'h0000_1000; exp_req(c, 4'b0001);
    tick(); cpud_request = 1'b0;
    tick(); rd[0] = 32'h1234_5678; slv_ack = 4'b0001; exp_ack(c + 2, 32'h1234_5678, 1'b0);
    tick(); slv_ack = '0;
    // Spurious ack from slave 2 while waiting on slave 1
    c = cyc; cpud_request = 1'b1; cpud_addr = 32'hE000_0004; exp_req(c, 4'b0010);
    tick(); cpud_request = 1'b0; slv_ack = 4'b0100; rd[2] = 32'hBAD0_BAD0;
    tick(2); slv_ack = 4'b0010; rd[1] = 32'hCAFE_0001; exp_ack(c + 3, 32'hCAFE_0001, 1'b0);
    tick(); slv_ack = '0;
    // Decode miss; acks and a new request during ERR are ignored
    c = cyc; cpud_request = 1'b1; cpud_addr = 32'h4000_0000; exp_ack(c + 1, 32'h0, 1'b1);
    tick(); cpud_addr = 32'h0000_0040; slv_ack = 4'hF;
    tick(); cpud_request = 1'b0; slv_ack = '0;
    // Timeout region (slave 3), no ack then ack on the boundary cycle
    c = cyc; cpud_request = 1'b1; cpud_addr = 32'h8000_0010; exp_req(c, 4'b1000);
    tick(); cpud_request = 1'b0;
`ifdef ADDRESS_ROUTER_TIMEOUT_EN
    exp_ack(c + 5, 32'h0, 1'b1);
    tick(5);
    c = cyc; cpud_request = 1'b1; exp_req(c, 4'b1000);
    tick(); cpud_request = 1'b0;
    tick(4); slv_ack = 4'b1000; rd[3] = 32'h3333_3333; exp_ack(c + 5, 32'h3333_3333, 1'b0);
    tick(); slv_ack = '0;
`else
    tick(9); slv_ack = 4'b1000; rd[3] = 32'h3333_3333; exp_ack(c + 10, 32'h3333_3333, 1'b0);
    tick(); slv_ack = '0;
`endif
    // Reset during WAIT abandons the transaction; late acks ignored
    c = cyc; cpud_request = 1'b1; cpud_addr = 32'h0000_1000; exp_req(c, 4'b0001);
    tick(); cpud_request = 1'b0;
    tick(); reset = 1'b1; slv_ack = 4'b0001; rd[0] = 32'hDEAD_0000;
    tick(); reset = 1'b0;
    tick(); slv_ack = '0;
    c = cyc; cpud_request = 1'b1; cpud_addr = 32'hE001_0020; exp_req(c, 4'b0100);
    tick(); cpud_request = 1'b0; slv_ack = 4'b0100; rd[2] = 32'h2222_0002; exp_ack(c + 1, 32'h2222_0002, 1'b0);
    tick(); slv_ack = '0;
    // Back-to-back hits: slave 0 then slave 1 in the cycle after the first ack
    c = cyc; cpud_request = 1'b1; cpud_addr = 32'h0000_0010; exp_req(c, 4'b0001);
    tick(); cpud_addr = 32'hE000_FFFC; slv_ack = 4'b0001; rd[0] = 32'hA0A0_A0A0; exp_ack(c + 1, 32'hA0A0_A0A0, 1'b0);
    tick(); slv_ack = '0; exp_req(c + 2, 4'b0010);
    tick(); cpud_request = 1'b0; slv_ack = 4'b0010; rd[1] = 32'hB1B1_B1B1; exp_ack(c + 3, 32'hB1B1_B1B1, 1'b0);
    tick(); slv_ack = '0;
    tick(3);
    check("ack_queue_drained", 64'(ack_q.size()), 64'(0));
    check("req_queue_drained", 64'(req_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
